// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported memory between the instruction-fetch unit (read only)
// and the load/store unit (read/write). Valid/ready requests, round-robin tie-break, one-cycle
// response pulses. Misaligned accesses are answered with an error and never reach memory.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ifu_req_*/ifu_raddr IFU fetch request (always a 32-bit access)
//   ifu_resp_*          IFU response pulse, zero-extended word, misalignment error
//   lsu_req_*/lsu_*     LSU request: wen, addr, wdata, access width
//   lsu_resp_*          LSU response pulse (loads and stores), load data, misalignment error
//   mem_*               memory-side read/write controls; mem_rdata valid the cycle after mem_ren
//
// Width encoding on *_wdt_op: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = 64 bit.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WDT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  // IFU
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_raddr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_resp_err,
  // LSU
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [WDT_W-1:0]  lsu_wdt_op,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_resp_err,
  // Memory
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [WDT_W-1:0]  mem_wdt_op,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WDT_W-1:0] WDT16 = WDT_W'(1);
  localparam logic [WDT_W-1:0] WDT32 = WDT_W'(2);
  localparam logic [WDT_W-1:0] WDT64 = WDT_W'(3);

  typedef enum logic [1:0] {StIdle, StRwait, StResp} state_t;

  state_t              r_state;
  logic                r_last_lsu;   // 1: most recent grant went to the LSU
  logic                r_owner_lsu;  // owner of the read in flight
  logic [ADDR_W-1:0]   r_addr;
  logic [WDT_W-1:0]    r_op;
  logic                r_ifu_resp_valid;
  logic [DATA_W-1:0]   r_ifu_rdata;
  logic                r_ifu_resp_err;
  logic                r_lsu_resp_valid;
  logic [DATA_W-1:0]   r_lsu_rdata;
  logic                r_lsu_resp_err;

  logic                w_idle;
  logic                w_pick_lsu;
  logic                w_grant_lsu;
  logic                w_grant_ifu;
  logic                w_grant;
  logic [ADDR_W-1:0]   w_g_addr;
  logic [WDT_W-1:0]    w_g_op;
  logic                w_g_wen;
  logic                w_misalign;

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign w_idle      = (r_state == StIdle) && !rst;
  // LSU wins when alone, or on a tie when the IFU was granted last.
  assign w_pick_lsu  = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
  assign w_grant_lsu = w_idle && w_pick_lsu;
  assign w_grant_ifu = w_idle && ifu_req_valid && !w_pick_lsu;
  assign w_grant     = w_grant_lsu || w_grant_ifu;

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  assign w_g_addr = w_grant_lsu ? lsu_addr : ifu_raddr;
  assign w_g_op   = w_grant_lsu ? lsu_wdt_op : WDT32;
  assign w_g_wen  = w_grant_lsu && lsu_wen;

  always_comb begin
    w_misalign = 1'b0;
    case (w_g_op)
      WDT16:   w_misalign = w_g_addr[0];
      WDT32:   w_misalign = |w_g_addr[1:0];
      WDT64:   w_misalign = |w_g_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  // Memory controls: driven from the request in the grant cycle, from the latched copy in
  // RWAIT (memory slices mem_rdata from raddr/op combinationally), otherwise all zero.
  always_comb begin
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wdt_op = '0;
    if (w_grant && !w_misalign) begin
      if (w_g_wen) begin
        mem_wen    = 1'b1;
        mem_waddr  = w_g_addr;
        mem_wdata  = lsu_wdata;
        mem_wdt_op = w_g_op;
      end else begin
        mem_ren    = 1'b1;
        mem_raddr  = w_g_addr;
        mem_wdt_op = w_g_op;
      end
    end else if (r_state == StRwait) begin
      mem_raddr  = r_addr;
      mem_wdt_op = r_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= StIdle;
      r_last_lsu       <= 1'b0;
      r_owner_lsu      <= 1'b0;
      r_addr           <= '0;
      r_op             <= '0;
      r_ifu_resp_valid <= 1'b0;
      r_ifu_rdata      <= '0;
      r_ifu_resp_err   <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_lsu_rdata      <= '0;
      r_lsu_resp_err   <= 1'b0;
    end else begin
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_last_lsu  <= w_grant_lsu;
            r_owner_lsu <= w_grant_lsu;
            if (w_misalign || w_g_wen) begin
              // Stores and errors answer straight away with zero data.
              r_state <= StResp;
              if (w_grant_lsu) begin
                r_lsu_resp_valid <= 1'b1;
                r_lsu_rdata      <= '0;
                r_lsu_resp_err   <= w_misalign;
              end else begin
                r_ifu_resp_valid <= 1'b1;
                r_ifu_rdata      <= '0;
                r_ifu_resp_err   <= 1'b1;
              end
            end else begin
              r_state <= StRwait;
              r_addr  <= w_g_addr;
              r_op    <= w_g_op;
            end
          end
        end
        StRwait: begin
          r_state <= StResp;
          if (r_owner_lsu) begin
            r_lsu_resp_valid <= 1'b1;
            r_lsu_rdata      <= mem_rdata;
            r_lsu_resp_err   <= 1'b0;
          end else begin
            r_ifu_resp_valid <= 1'b1;
            r_ifu_rdata      <= DATA_W'(mem_rdata[31:0]);
            r_ifu_resp_err   <= 1'b0;
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ifu_resp_valid = r_ifu_resp_valid;
  assign ifu_rdata      = r_ifu_rdata;
  assign ifu_resp_err   = r_ifu_resp_err;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign lsu_rdata      = r_lsu_rdata;
  assign lsu_resp_err   = r_lsu_resp_err;

endmodule
